// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl -- four-digit multiplexed seven-segment scan controller.
//
// Each digit owns a slot of SCAN_DIV+1 clk cycles. The first GUARD cycles of
// every slot keep all anodes off to avoid ghosting. The remaining cycles drive
// the anode and the segments of the current digit. A 16-bit shadow value and a
// 4-bit decimal-point shadow feed the display. These shadows change only at the
// frame boundary, where the digit index wraps from 3 back to 0, so one frame
// never mixes old and new data.
//
// Parameters
//   SCAN_DIV : slot length minus one, in clk cycles
//   GUARD    : anode-off cycles at the start of each slot (0 <= GUARD < SCAN_DIV)
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   load_req   in   request to load value/dp_in, held until load_ack
//   value      in   four hex nibbles; value[3:0] is digit 0 (rightmost)
//   dp_in      in   per-digit decimal point, active-high
//   load_ack   out  one-cycle pulse when value/dp_in were captured
//   an         out  anode enables, active-low; an[i] drives digit i
//   seg        out  segments {g,f,e,d,c,b,a}, active-low
//   dp         out  decimal-point segment, active-low
//   frame_done out  one-cycle pulse at each frame boundary
//
// Optional feature
//   SEG_LZB_EN : when defined, leading-zero blanking is enabled. Digits 3..1
//                stay dark while they and every more-significant nibble are
//                zero. Digit 0 always shows.
module seg_scan_ctrl #(
    parameter int SCAN_DIV = 99999,
    parameter int GUARD    = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_req,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    output logic        load_ack,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int CW = (SCAN_DIV > 0) ? $clog2(SCAN_DIV + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(SCAN_DIV);
    localparam logic [CW-1:0] GUARD_CNT = CW'(GUARD);

    typedef enum logic [1:0] {ST_BLANK, ST_GUARD, ST_SHOW} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    idx, idx_n;
    logic [15:0]   shadow, shadow_n;
    logic [3:0]    shadow_dp, shadow_dp_n;
    logic          boundary, capture, lzb;
    logic [3:0]    an_n, nibble;
    logic [6:0]    seg_n;
    logic          dp_n;

    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

`ifdef SEG_LZB_EN
    // True when digit i and every more-significant nibble are zero.
    function automatic logic leading_zero(input logic [15:0] s, input logic [1:0] i);
        logic z;
        case (i)
            2'd3:    z = (s[15:12] == 4'h0);
            2'd2:    z = (s[15:8] == 8'h00);
            2'd1:    z = (s[15:4] == 12'h000);
            default: z = 1'b0;
        endcase
        return z;
    endfunction
`endif

    // Next-state values. Outputs are decoded from these values, so the
    // registered outputs change on the same edge as the state.
    always_comb begin
        cnt_n       = (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
        idx_n       = idx;
        state_n     = state;
        boundary    = 1'b0;
        if (cnt == CNT_MAX) begin
            if (state == ST_BLANK) begin
                // The first wrap ends BLANK and starts frame 0 at digit 0.
                idx_n    = 2'd0;
                boundary = 1'b1;
            end else begin
                idx_n    = idx + 2'd1;
                boundary = (idx == 2'd3);
            end
        end
        if (state != ST_BLANK || cnt == CNT_MAX) begin
            state_n = (cnt_n < GUARD_CNT) ? ST_GUARD : ST_SHOW;
        end

        capture     = boundary && load_req;
        shadow_n    = capture ? value : shadow;
        shadow_dp_n = capture ? dp_in : shadow_dp;

        nibble = shadow_n[{idx_n, 2'b00} +: 4];
`ifdef SEG_LZB_EN
        lzb = leading_zero(shadow_n, idx_n);
`else
        lzb = 1'b0;
`endif
        an_n  = 4'b1111;
        seg_n = 7'h7F;
        dp_n  = 1'b1;
        if (state_n == ST_SHOW && !lzb) begin
            an_n  = ~(4'b0001 << idx_n);
            seg_n = hex_glyph(nibble);
            dp_n  = ~shadow_dp_n[idx_n];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_BLANK;
            cnt        <= '0;
            idx        <= 2'd0;
            shadow     <= 16'h0000;
            shadow_dp  <= 4'h0;
            an         <= 4'b1111;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            load_ack   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            shadow     <= shadow_n;
            shadow_dp  <= shadow_dp_n;
            an         <= an_n;
            seg        <= seg_n;
            dp         <= dp_n;
            load_ack   <= capture;
            frame_done <= boundary;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl with SCAN_DIV=9 and GUARD=2. A behavioural model
// tracks edges since reset release and derives slot, digit and boundary timing
// with plain arithmetic. A compare process checks every cycle, and literal
// checks at fixed points pin the expected waveform.
module tb_seg_scan_ctrl;

    localparam int SD   = 9;
    localparam int GD   = 2;
    localparam int SLOT = SD + 1;
    localparam int FRM  = 4 * SLOT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_req = 1'b0;
    logic [15:0] value = 16'h0000;
    logic [3:0]  dp_in = 4'h0;
    logic        load_ack;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    seg_scan_ctrl #(.SCAN_DIV(SD), .GUARD(GD)) dut (
        .clk(clk), .rst(rst), .load_req(load_req), .value(value), .dp_in(dp_in),
        .load_ack(load_ack), .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Model state: edges since reset release, shadows, pulse expectations.
    int          e = 0;
    logic [15:0] m_shadow = 16'h0;
    logic [3:0]  m_sdp = 4'h0;
    logic        m_ack = 1'b0;
    logic        m_fd = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            e = 0; m_shadow = 16'h0; m_sdp = 4'h0; m_ack = 1'b0; m_fd = 1'b0;
        end else begin
            e = e + 1;
            m_ack = 1'b0;
            m_fd  = 1'b0;
            if (e >= SLOT && (e - SLOT) % FRM == 0) begin
                m_fd = 1'b1;
                if (load_req) begin
                    m_shadow = value; m_sdp = dp_in; m_ack = 1'b1;
                end
            end
        end
    end

    task automatic model_out(input int ee, input logic [15:0] sh, input logic [3:0] sd,
                             output logic [3:0] ea, output logic [6:0] es, output logic ed);
        int w, d;
        logic dark;
        ea = 4'hF; es = 7'h7F; ed = 1'b1;
        if (ee >= SLOT) begin
            w = (ee - SLOT) % SLOT;
            d = ((ee - SLOT) / SLOT) % 4;
            dark = (w < GD);
`ifdef SEG_LZB_EN
            if (d > 0 && (sh >> (4 * d)) == 16'h0) dark = 1'b1;
`endif
            if (!dark) begin
                ea = 4'hF & ~(4'b0001 << d);
                es = glyph[(sh >> (4 * d)) & 16'hF];
                ed = ~sd[d];
            end
        end
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at e=%0d: got %h expected %h", nm, e, act, exp);
        end
    endtask

    logic cmp_en = 1'b0;
    always @(negedge clk) begin
        logic [3:0] ea;
        logic [6:0] es;
        logic       ed;
        if (cmp_en && !rst) begin
            model_out(e, m_shadow, m_sdp, ea, es, ed);
            chk("an", {12'h0, an}, {12'h0, ea});
            chk("seg", {9'h0, seg}, {9'h0, es});
            chk("dp", {15'h0, dp}, {15'h0, ed});
            chk("load_ack", {15'h0, load_ack}, {15'h0, m_ack});
            chk("frame_done", {15'h0, frame_done}, {15'h0, m_fd});
        end
    end

    // Advance to the negedge after the given edge count, bounded.
    task automatic goto(input int target);
        int n = 0;
        while (e < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (e != target) begin
            checks++;
            errors++;
            $display("FAIL goto: reached e=%0d, wanted %0d", e, target);
        end
    endtask

    task automatic lit_blank(input string nm);
        chk({nm, "_an"}, {12'h0, an}, 16'h000F);
        chk({nm, "_seg"}, {9'h0, seg}, 16'h007F);
    endtask

    initial begin
        int e1, n;
        repeat (3) @(negedge clk);
        // Reset state while rst is held.
        lit_blank("rst_hold");
        chk("rst_ack", {15'h0, load_ack}, 16'h0);
        rst = 1'b0;
        cmp_en = 1'b1;

        // Blank for one slot, guard, then digit 0 shows '0'.
        goto(5);  lit_blank("blank5");
        goto(10); chk("exit_fd", {15'h0, frame_done}, 16'h1);
                  chk("exit_ack", {15'h0, load_ack}, 16'h0);
        goto(11); lit_blank("guard11");
        goto(12); chk("show12_an", {12'h0, an}, 16'h000E);
                  chk("show12_seg", {9'h0, seg}, 16'h0040);

        // Load 0x1234 mid-frame; capture at the boundary at edge 50.
        goto(20); load_req = 1'b1; value = 16'h1234; dp_in = 4'b0001;
        goto(50); chk("ld_ack", {15'h0, load_ack}, 16'h1);
                  chk("ld_fd", {15'h0, frame_done}, 16'h1);
                  load_req = 1'b0;
        goto(51); chk("ld_ack_once", {15'h0, load_ack}, 16'h0);
        goto(52); chk("d0_an", {12'h0, an}, 16'h000E);
                  chk("d0_seg", {9'h0, seg}, 16'h0019);
                  chk("d0_dp", {15'h0, dp}, 16'h0);
                  chk("model_shadow", m_shadow, 16'h1234);
        goto(82); chk("d3_an", {12'h0, an}, 16'h0007);
                  chk("d3_seg", {9'h0, seg}, 16'h0079);

        // A request withdrawn before the boundary is not captured.
        goto(83); load_req = 1'b1; value = 16'hABCD; dp_in = 4'hF;
        goto(88); load_req = 1'b0;
        goto(90); chk("nold_ack", {15'h0, load_ack}, 16'h0);
                  chk("nold_fd", {15'h0, frame_done}, 16'h1);
        goto(92); chk("keep_seg", {9'h0, seg}, 16'h0019);

        // Asynchronous reset during digit 2 show.
        goto(115); chk("d2_an", {12'h0, an}, 16'h000B);
                   chk("d2_seg", {9'h0, seg}, 16'h0024);
        #2 rst = 1'b1;
        #1 lit_blank("async_rst");
        chk("async_dp", {15'h0, dp}, 16'h1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        load_req = 1'b1; value = 16'h0050; dp_in = 4'h0;
        goto(5);  lit_blank("reblank5");
        goto(10); chk("lz_ack", {15'h0, load_ack}, 16'h1);
                  load_req = 1'b0;
        goto(12); chk("lz_d0_an", {12'h0, an}, 16'h000E);
                  chk("lz_d0_seg", {9'h0, seg}, 16'h0040);
        goto(22); chk("lz_d1_an", {12'h0, an}, 16'h000D);
                  chk("lz_d1_seg", {9'h0, seg}, 16'h0012);
`ifdef SEG_LZB_EN
        goto(32); lit_blank("lz_d2");
        goto(42); lit_blank("lz_d3");
`else
        goto(32); chk("lz_d2_an", {12'h0, an}, 16'h000B);
                  chk("lz_d2_seg", {9'h0, seg}, 16'h0040);
        goto(42); chk("lz_d3_an", {12'h0, an}, 16'h0007);
                  chk("lz_d3_seg", {9'h0, seg}, 16'h0040);
`endif

        // frame_done spacing in free run.
        n = 0;
        while (!frame_done && n < 100) begin @(negedge clk); n++; end
        e1 = e;
        @(negedge clk);
        n = 0;
        while (!frame_done && n < 100) begin @(negedge clk); n++; end
        chk("fd_period", 16'(e - e1), 16'(FRM));

        // Randomized loads; the compare process checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 9) < 2) load_req = ~load_req;
            if ($urandom_range(0, 3) == 0) value = 16'($urandom);
            if ($urandom_range(0, 3) == 0) dp_in = 4'($urandom);
        end

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
